// File: rtl/gecko_writeback.sv
// gecko_writeback: arbitrates the execute, memory and system result streams
// into the single register-file write port, one result per cycle.
// Payload layout on every *_data input: {addr[4:0], speculative, value[31:0]}.
module gecko_writeback #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        execute_result_valid,
  output logic        execute_result_ready,
  input  logic [37:0] execute_result_data,
  input  logic        memory_result_valid,
  output logic        memory_result_ready,
  input  logic [37:0] memory_result_data,
  input  logic        system_result_valid,
  output logic        system_result_ready,
  input  logic [37:0] system_result_data,
  input  logic        clear_speculative,
  output logic        reg_write_enable,
  output logic [4:0]  reg_write_addr,
  output logic [31:0] reg_write_value,
  output logic [1:0]  retired_instructions
);

  typedef enum logic [1:0] {
    SRC_EXECUTE = 2'd0,
    SRC_MEMORY  = 2'd1,
    SRC_SYSTEM  = 2'd2
  } source_t;

  source_t     rr_ptr;
  logic [2:0]  valid_vec;
  logic [2:0]  grant;
  logic [37:0] granted_data;
  logic        transfer;
  logic        keep_result;

  assign valid_vec = {system_result_valid, memory_result_valid, execute_result_valid};

  // Choose at most one source per cycle; nothing is granted while in reset.
  always_comb begin
    grant = 3'b000;
    if (FIXED_PRIORITY) begin
      if (valid_vec[2])      grant = 3'b100;
      else if (valid_vec[1]) grant = 3'b010;
      else if (valid_vec[0]) grant = 3'b001;
    end else begin
      case (rr_ptr)
        SRC_EXECUTE: begin
          if (valid_vec[0])      grant = 3'b001;
          else if (valid_vec[1]) grant = 3'b010;
          else if (valid_vec[2]) grant = 3'b100;
        end
        SRC_MEMORY: begin
          if (valid_vec[1])      grant = 3'b010;
          else if (valid_vec[2]) grant = 3'b100;
          else if (valid_vec[0]) grant = 3'b001;
        end
        SRC_SYSTEM: begin
          if (valid_vec[2])      grant = 3'b100;
          else if (valid_vec[0]) grant = 3'b001;
          else if (valid_vec[1]) grant = 3'b010;
        end
        default: grant = 3'b000;
      endcase
    end
    if (rst) grant = 3'b000;
  end

  assign execute_result_ready = grant[0];
  assign memory_result_ready  = grant[1];
  assign system_result_ready  = grant[2];
  assign transfer             = |grant;

  // Route the granted payload; a speculative result is dropped when a flush is requested.
  always_comb begin
    granted_data = '0;
    case (grant)
      3'b001:  granted_data = execute_result_data;
      3'b010:  granted_data = memory_result_data;
      3'b100:  granted_data = system_result_data;
      default: granted_data = '0;
    endcase
    keep_result = !(granted_data[32] && clear_speculative);
  end

  // Move the round-robin pointer to the source after the one just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= SRC_EXECUTE;
    end else if (transfer) begin
      case (grant)
        3'b001:  rr_ptr <= SRC_MEMORY;
        3'b010:  rr_ptr <= SRC_SYSTEM;
        3'b100:  rr_ptr <= SRC_EXECUTE;
        default: rr_ptr <= rr_ptr;
      endcase
    end
  end

  // Register the write port; x0 retires without writing, flushed results neither write nor retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_enable     <= 1'b0;
      reg_write_addr       <= 5'd0;
      reg_write_value      <= 32'd0;
      retired_instructions <= 2'd0;
    end else if (transfer) begin
      reg_write_enable     <= keep_result && (granted_data[37:33] != 5'd0);
      reg_write_addr       <= granted_data[37:33];
      reg_write_value      <= granted_data[31:0];
      retired_instructions <= {1'b0, keep_result};
    end else begin
      reg_write_enable     <= 1'b0;
      retired_instructions <= 2'd0;
    end
  end

endmodule

// File: tb/tb_gecko_writeback.sv
// tb_gecko_writeback: drives a round-robin and a fixed-priority instance with
// directed and random result streams and compares against a behavioural model.
module tb_gecko_writeback;

  logic        clk;
  logic        rst;
  logic [2:0]  vld [2];
  logic [37:0] dat [2][3];
  logic        clr [2];

  logic [2:0]  nv [2];
  logic [37:0] nd [2][3];
  logic        nclr [2];

  wire [2:0]  rdy0, rdy1;
  wire        en0, en1;
  wire [4:0]  addr0, addr1;
  wire [31:0] val0, val1;
  wire [1:0]  ret0, ret1;

  int n_compared   = 0;
  int n_mismatched = 0;

  string dut_name [2] = '{"rr", "fp"};

  int          ptr [2];
  int          last_grant [2];
  logic        exp_en [2];
  logic [4:0]  exp_addr [2];
  logic [31:0] exp_val [2];
  logic [1:0]  exp_ret [2];

  gecko_writeback #(.FIXED_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .rst(rst),
    .execute_result_valid(vld[0][0]), .execute_result_ready(rdy0[0]), .execute_result_data(dat[0][0]),
    .memory_result_valid(vld[0][1]),  .memory_result_ready(rdy0[1]),  .memory_result_data(dat[0][1]),
    .system_result_valid(vld[0][2]),  .system_result_ready(rdy0[2]),  .system_result_data(dat[0][2]),
    .clear_speculative(clr[0]),
    .reg_write_enable(en0), .reg_write_addr(addr0), .reg_write_value(val0),
    .retired_instructions(ret0)
  );

  gecko_writeback #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .execute_result_valid(vld[1][0]), .execute_result_ready(rdy1[0]), .execute_result_data(dat[1][0]),
    .memory_result_valid(vld[1][1]),  .memory_result_ready(rdy1[1]),  .memory_result_data(dat[1][1]),
    .system_result_valid(vld[1][2]),  .system_result_ready(rdy1[2]),  .system_result_data(dat[1][2]),
    .clear_speculative(clr[1]),
    .reg_write_enable(en1), .reg_write_addr(addr1), .reg_write_value(val1),
    .retired_instructions(ret1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0]  obs_rdy(input int d);  return (d == 1) ? rdy1  : rdy0;  endfunction
  function automatic logic        obs_en(input int d);   return (d == 1) ? en1   : en0;   endfunction
  function automatic logic [4:0]  obs_addr(input int d); return (d == 1) ? addr1 : addr0; endfunction
  function automatic logic [31:0] obs_val(input int d);  return (d == 1) ? val1  : val0;  endfunction
  function automatic logic [1:0]  obs_ret(input int d);  return (d == 1) ? ret1  : ret0;  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference arbiter: d=0 rotates from ptr[0] (0=execute,1=memory,2=system), d=1 prefers system > memory > execute.
  function automatic int model_grant(input int d);
    if (d == 1) begin
      for (int k = 2; k >= 0; k--) if (vld[1][k]) return k;
      return -1;
    end
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (ptr[0] + k) % 3;
      if (vld[0][s]) return s;
    end
    return -1;
  endfunction

  function automatic logic [37:0] payload(input logic [4:0] a, input logic spec, input logic [31:0] v);
    return {a, spec, v};
  endfunction

  function automatic logic [37:0] rand_payload();
    logic [4:0] a;
    a = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    return {a, 1'($urandom_range(0, 1)), 32'($urandom)};
  endfunction

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0; last_grant[d] = -1;
      exp_en[d] = 1'b0; exp_addr[d] = '0; exp_val[d] = '0; exp_ret[d] = '0;
    end
  endtask

  task automatic clearInputs();
    for (int d = 0; d < 2; d++) begin
      nv[d] = 3'b000; nclr[d] = 1'b0;
      for (int s = 0; s < 3; s++) nd[d][s] = '0;
    end
  endtask

  // One clock cycle: drive nv/nd/nclr, check ready against the model, then check the registered result.
  task automatic applyStimulus();
    for (int d = 0; d < 2; d++) begin
      vld[d] = nv[d]; clr[d] = nclr[d];
      for (int s = 0; s < 3; s++) dat[d][s] = nd[d][s];
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      int g;
      logic [37:0] p;
      g = model_grant(d);
      checkOutput({dut_name[d], ".ready"}, 64'(obs_rdy(d)), (g >= 0) ? 64'(3'b001 << g) : 64'd0);
      last_grant[d] = g;
      if (g >= 0) begin
        p = dat[d][g];
        exp_ret[d]  = (p[32] && clr[d]) ? 2'd0 : 2'd1;
        exp_en[d]   = (exp_ret[d] == 2'd1) && (p[37:33] != 5'd0);
        exp_addr[d] = p[37:33];
        exp_val[d]  = p[31:0];
        if (d == 0) ptr[0] = (g + 1) % 3;
      end else begin
        exp_en[d]  = 1'b0;
        exp_ret[d] = 2'd0;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput({dut_name[d], ".enable"}, 64'(obs_en(d)), 64'(exp_en[d]));
      checkOutput({dut_name[d], ".retired"}, 64'(obs_ret(d)), 64'(exp_ret[d]));
      if (exp_en[d]) begin
        checkOutput({dut_name[d], ".addr"}, 64'(obs_addr(d)), 64'(exp_addr[d]));
        checkOutput({dut_name[d], ".value"}, 64'(obs_val(d)), 64'(exp_val[d]));
      end
    end
  endtask

  // Random cycle: an ungranted valid input keeps its payload, others are redrawn.
  task automatic randomCycle();
    for (int d = 0; d < 2; d++) begin
      nclr[d] = ($urandom_range(0, 3) == 0);
      for (int s = 0; s < 3; s++) begin
        if (!(vld[d][s] && last_grant[d] != s)) begin
          nv[d][s] = ($urandom_range(0, 99) < 60);
          nd[d][s] = rand_payload();
        end
      end
    end
    applyStimulus();
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput({dut_name[d], ".", tag, ".enable"},  64'(obs_en(d)),   64'd0);
      checkOutput({dut_name[d], ".", tag, ".addr"},    64'(obs_addr(d)), 64'd0);
      checkOutput({dut_name[d], ".", tag, ".value"},   64'(obs_val(d)),  64'd0);
      checkOutput({dut_name[d], ".", tag, ".retired"}, 64'(obs_ret(d)),  64'd0);
      checkOutput({dut_name[d], ".", tag, ".ready"},   64'(obs_rdy(d)),  64'd0);
    end
  endtask

  initial begin
    resetModel();
    clearInputs();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 3'b111; clr[d] = 1'b0;
      for (int s = 0; s < 3; s++) dat[d][s] = payload(5'd1, 1'b0, 32'h1);
    end
    #3;
    checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset_hold");
    rst = 1'b0;

    $display("[TB] contention from reset");
    for (int d = 0; d < 2; d++) begin
      nv[d] = 3'b111;
      for (int s = 0; s < 3; s++) nd[d][s] = payload(5'(10 + s), 1'b0, 32'(100 * (s + 1)));
    end
    repeat (4) applyStimulus();

    $display("[TB] single execute transfer");
    clearInputs();
    applyStimulus();
    nv[0] = 3'b001; nd[0][0] = payload(5'd5, 1'b0, 32'hDEADBEEF);
    applyStimulus();
    checkOutput("rr.single.addr",  64'(addr0), 64'd5);
    checkOutput("rr.single.value", 64'(val0),  64'hDEADBEEF);

    $display("[TB] x0 and flush");
    clearInputs();
    nv[0] = 3'b100; nd[0][2] = payload(5'd0, 1'b0, 32'd7);
    applyStimulus();
    checkOutput("rr.x0.retired", 64'(ret0), 64'd1);
    clearInputs();
    nv[0] = 3'b001; nd[0][0] = payload(5'd3, 1'b1, 32'h55); nclr[0] = 1'b1;
    applyStimulus();
    checkOutput("rr.flush.retired", 64'(ret0), 64'd0);
    clearInputs();
    nv[0] = 3'b001; nd[0][0] = payload(5'd3, 1'b1, 32'h66);
    applyStimulus();
    checkOutput("rr.spec_keep.enable", 64'(en0), 64'd1);

    $display("[TB] fixed priority memory and system together");
    clearInputs();
    nv[1] = 3'b110; nd[1][1] = payload(5'd8, 1'b0, 32'h88); nd[1][2] = payload(5'd9, 1'b0, 32'h99);
    applyStimulus();
    checkOutput("fp.first.addr", 64'(addr1), 64'd9);
    nv[1] = 3'b010;
    applyStimulus();
    checkOutput("fp.second.addr", 64'(addr1), 64'd8);

    $display("[TB] random traffic");
    clearInputs();
    applyStimulus();
    repeat (400) randomCycle();

    $display("[TB] reset mid-stream");
    clearInputs();
    for (int d = 0; d < 2; d++) begin
      nv[d] = 3'b010; nd[d][1] = payload(5'd9, 1'b0, 32'hCAFE0001);
    end
    applyStimulus();
    for (int d = 0; d < 2; d++) begin
      vld[d] = 3'b111; clr[d] = 1'b0;
      for (int s = 0; s < 3; s++) dat[d][s] = payload(5'd12, 1'b0, 32'h1234);
    end
    #2 rst = 1'b1;
    #1;
    checkResetOutputs("async_reset");
    @(posedge clk);
    #1;
    checkResetOutputs("reset_edge");
    rst = 1'b0;
    resetModel();
    clearInputs();
    applyStimulus();
    for (int d = 0; d < 2; d++) begin
      nv[d] = 3'b111;
      for (int s = 0; s < 3; s++) nd[d][s] = payload(5'(20 + s), 1'b0, 32'(s + 1));
    end
    applyStimulus();
    checkOutput("rr.restart.addr", 64'(addr0), 64'd20);
    repeat (3) applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/gecko_writeback.md
GECKO_WRITEBACK -- requirements
Module: gecko_writeback

Interface
REQ-001 SHALL have parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin arbitration and 1 = fixed priority system > memory > execute.
REQ-002 SHALL have port clk  input  1  the single clock, all state on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port execute_result  std_stream_intf.in  38  gecko_operation_t payload {addr[4:0], speculative, value[31:0]}, with valid/ready.
REQ-005 SHALL have port memory_result  std_stream_intf.in  38  gecko_operation_t payload from the load path.
REQ-006 SHALL have port system_result  std_stream_intf.in  38  gecko_operation_t payload from the system/CSR stage.
REQ-007 SHALL have port clear_speculative  input  1  when high, speculative results accepted this cycle are discarded.
REQ-008 SHALL have port reg_write_enable  output  1  register-file write strobe.
REQ-009 SHALL have port reg_write_addr  output  5  register-file write address.
REQ-010 SHALL have port reg_write_value  output  32  register-file write data.
REQ-011 SHALL have port retired_instructions  output  2  gecko_retired_count_t, the number of results retired last cycle (0 or 1).

Function
REQ-012 SHALL accept at most one input per cycle; a transfer occurs on an input when its valid and ready are both high.
REQ-013 SHALL drive ready combinationally: high only on the granted input, low on all others; ready SHALL NOT depend on any output back-pressure, because the register file always accepts.
REQ-014 SHALL, when FIXED_PRIORITY=0, grant the first valid input in rotation order execute -> memory -> system, starting at the round-robin pointer.
REQ-015 SHALL advance the pointer to the input after the grantee on every grant, and hold the pointer when nothing is granted.
REQ-016 SHALL, when FIXED_PRIORITY=1, grant system, then memory, then execute, and ignore the pointer.
REQ-017 SHALL register the outputs: the transfer at cycle N appears on reg_write_* and retired_instructions at cycle N+1, for exactly one cycle.
REQ-018 SHALL consume a transfer whose addr is 0 with reg_write_enable=0 and retired_instructions=1, because x0 is never written.
REQ-019 SHALL consume and discard a transfer with speculative=1 while clear_speculative=1 that cycle: reg_write_enable=0 and retired_instructions=0.
REQ-020 SHALL write a transfer with speculative=1 while clear_speculative=0 normally, with retired_instructions=1.
REQ-021 SHALL drive reg_write_enable=0 and retired_instructions=0 in any cycle following no transfer; reg_write_addr and reg_write_value SHALL hold their last values.
REQ-022 SHALL pass value through unmodified, with addr taken only from the granted payload.
REQ-023 SHALL guarantee that an ungranted valid input keeps its payload stable and is granted within 3 cycles under round-robin, i.e. no starvation.

Reset
REQ-024 SHALL, while rst is high, asynchronously force reg_write_enable=0, reg_write_addr=0, reg_write_value=0, retired_instructions=0, pointer=execute, and all input ready=0.
REQ-025 SHALL ensure that a transfer in flight when rst asserts never produces a write after reset deasserts.
REQ-026 SHALL resume arbitration on the first rising clk after rst deasserts.

Verification
REQ-027 Single path: execute valid {addr=5, spec=0, value=0xDEADBEEF} -> execute ready=1 that cycle; next cycle enable=1, addr=5, value=0xDEADBEEF, retired=1.
REQ-028 Round-robin contention: all three inputs valid continuously from reset -> grants execute, memory, system, execute, ... one per cycle; each writes on the following cycle.
REQ-029 x0 and flush: system {addr=0, value=7} -> enable=0, retired=1; execute {addr=3, spec=1} with clear_speculative=1 -> enable=0, retired=0.
REQ-030 Fixed priority (FIXED_PRIORITY=1): memory and system valid together -> system granted first, memory granted on the next cycle.
REQ-031 Reset mid-stream: rst pulsed asynchronously between edges right after a transfer -> outputs are 0 immediately, no write follows, and the pointer restarts at execute.
